keypad_entry_display: RTL
=========================

Name: keypad_entry_display

Overview:
- Downstream consumer of the 4x3 keypad scanner.
- Takes the scanner's 4-bit keycode and its raw press level (OR of the column lines), which are asynchronous to fin.
- Debounces each press and interprets it as a digit, CLEAR or ENTER. Builds a 4-digit BCD entry.
- Multiplexes the entry onto a 4-digit 7-segment display and emits a committed value with a one-cycle valid strobe.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive fin cycles the synchronised press level must hold to be accepted (press or release); minimum 2.
- REFRESH_BITS, 16, width of the display refresh counter; the digit advances when the counter wraps.

Ports:
- fin  input  1  system clock; all logic on posedge fin.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  high: keys accepted and display driven; low: see Behaviour.
- keycode  input  4  scanner keycode, asynchronous; 0-9 digit, 10 CLEAR, 11 ENTER, 12-15 ignored.
- press  input  1  raw key-down level from the scanner, asynchronous.
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- dig_sel  output  4  one-hot digit enable, active-high; bit0 = rightmost digit.
- entry_bcd  output  16  last committed entry, 4 BCD digits; [3:0] = least significant.
- entry_valid  output  1  one-cycle pulse when entry_bcd updates.
- digit_count  output  3  digits currently in the edit buffer, 0-4.

Behaviour:
- Synchronisation:
  - press and keycode each pass through a 2-flop synchroniser on fin.
  - All downstream logic uses only the synchronised copies.
- Debounce FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: sync press=1 -> PRESS_WAIT, debounce counter=0.
  - PRESS_WAIT: press=0 -> IDLE. When the counter reaches DEBOUNCE_CYCLES-1 with press still 1 -> HELD. On that transition cycle the synchronised keycode is sampled and one accept event fires.
  - HELD: press=0 -> RELEASE_WAIT, counter=0.
  - RELEASE_WAIT: press=1 -> HELD with no new event (bounce). When the counter reaches DEBOUNCE_CYCLES-1 with press 0 -> IDLE.
  - Exactly one accept event per physical press. Holding a key never repeats.
- Accept event actions, applied the same cycle the event fires:
  - Digit d (0-9), digit_count<4: buf <= {buf[11:0], d}; digit_count++.
  - Digit with digit_count==4: ignored; buf unchanged.
  - CLEAR: buf <= 0; digit_count <= 0.
  - ENTER with digit_count>0: entry_bcd <= buf, registered so it is visible the next cycle; entry_valid=1 for exactly that next cycle; buf <= 0; digit_count <= 0.
  - ENTER with digit_count==0: no update, no pulse.
  - Codes 12-15: no effect.
- Display:
  - The refresh counter free-runs.
  - On wrap, digit index i increments mod 4 and dig_sel = 1<<i.
  - seg shows buf[4i+3:4i] through the BCD-to-7-seg table (0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111).
  - Positions i >= digit_count show seg=0 (blank), so an empty buffer is fully blank.
  - seg and dig_sel are registered and change together.
- enable low:
  - The FSM is forced to IDLE and no events fire.
  - dig_sel=0 and seg=0.
  - buf, digit_count and entry_bcd are retained.
  - The refresh counter keeps running.
- Reset (synchronous, dominates everything, including mid-debounce and mid-display):
  - FSM IDLE; synchronisers, debounce counter, refresh counter, buf, digit_count and entry_bcd all 0.
  - entry_valid=0; seg=0; dig_sel=0; digit index 0.
- Latency: accept event fires DEBOUNCE_CYCLES+2 cycles after raw press rises cleanly. This is 2 synchroniser cycles plus DEBOUNCE_CYCLES, counted from the PRESS_WAIT entry cycle.

Decomposition:
- Package keypad_pkg:
  - KEY_CLEAR=4'd10, KEY_ENTER=4'd11.
  - The debounce state encoding.
  - The 10-entry seg7 pattern constant and the blank pattern.
- One sub-module, key_debounce: synchroniser + 4-state FSM + counter. It outputs a one-cycle accept strobe and the sampled keycode.
- The top module holds the edit buffer, commit register and display mux.

Test Plan (DEBOUNCE_CYCLES=4, REFRESH_BITS=2):
- Reset, then key 7 cleanly held 20 cycles and released 20 cycles -> exactly one event; digit_count=1; buf=0x0007; display shows "7" on dig_sel=0001 and other positions blank.
- Press toggling 1,0,1,0 every cycle for 10 cycles, then stable low -> no event, digit_count stays 0.
- Keys 1,2,3,4,5, then ENTER -> the fifth digit is ignored. The cycle after the ENTER event: entry_bcd=0x1234 and entry_valid=1 for exactly one cycle. Then digit_count=0 and the display is blank.
- Keys 9,8 then CLEAR, then ENTER -> buf=0 and digit_count=0; no entry_valid pulse; entry_bcd unchanged.
- Key held 100 cycles with a 2-cycle release glitch mid-hold -> single event only.
- Assert rst for one cycle mid-PRESS_WAIT with digit_count=3 -> next cycle: all state 0, seg=0, dig_sel=0, no event from the interrupted press.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Key codes, debounce state encoding and 7-segment patterns.
// Revision : 1.0
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_t;

    // Segment order {g,f,e,d,c,b,a}; entry [0] is digit 0.
    localparam logic [9:0][6:0] C_SEG7 = {
        7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
        7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };
    localparam logic [6:0] C_SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        if (d <= 4'd9) begin
            return C_SEG7[d];
        end
        return C_SEG_BLANK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : 2-flop synchronisers plus press/release debounce FSM; emits one
//            accept strobe per debounced press together with the key code.
// Revision : 1.0
// ============================================================================
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic [3:0] i_keycode,
    input  logic       i_press,
    output logic       o_accept,
    output logic [3:0] o_key
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_press_s1;
    logic             r_press_s2;
    logic [3:0]       r_key_s1;
    logic [3:0]       r_key_s2;
    deb_state_t       r_state;
    deb_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_press_s1 <= 1'b0;
            r_press_s2 <= 1'b0;
            r_key_s1   <= 4'd0;
            r_key_s2   <= 4'd0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
        end else begin
            r_press_s1 <= i_press;
            r_press_s2 <= r_press_s1;
            r_key_s1   <= i_keycode;
            r_key_s2   <= r_key_s1;
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_press_s2) begin
                    w_state_next = ST_PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_press_s2) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_next = ST_HELD;
                    w_accept     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!r_press_s2) begin
                    w_state_next = ST_RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // A return to high here is contact bounce, not a new press.
                if (r_press_s2) begin
                    w_state_next = ST_HELD;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (!i_enable) begin
            w_state_next = ST_IDLE;
            w_accept     = 1'b0;
        end
    end

    assign o_accept = w_accept;
    assign o_key    = r_key_s2;

endmodule
`default_nettype wire

// File: rtl/keypad_entry_display.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry_display
// Brief    : Debounced keypad entry into a 4-digit BCD buffer with commit
//            strobe and multiplexed 7-segment display.
// Revision : 1.0
// ============================================================================
module keypad_entry_display
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REFRESH_BITS    = 16
) (
    input  logic        fin,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  keycode,
    input  logic        press,
    output logic [6:0]  seg,
    output logic [3:0]  dig_sel,
    output logic [15:0] entry_bcd,
    output logic        entry_valid,
    output logic [2:0]  digit_count
);

    logic                    w_accept;
    logic [3:0]              w_key;
    logic [15:0]             r_buf;
    logic [2:0]              r_count;
    logic [15:0]             r_entry;
    logic                    r_valid;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [1:0]              r_idx;
    logic [6:0]              r_seg;
    logic [3:0]              r_dig;
    logic [3:0]              w_cur_digit;
    logic                    w_cur_shown;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (fin),
        .rst      (rst),
        .i_enable (enable),
        .i_keycode(keycode),
        .i_press  (press),
        .o_accept (w_accept),
        .o_key    (w_key)
    );

    always_ff @(posedge fin) begin
        if (rst) begin
            r_buf   <= 16'd0;
            r_count <= 3'd0;
            r_entry <= 16'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                if (w_key <= 4'd9) begin
                    if (r_count != 3'd4) begin
                        r_buf   <= {r_buf[11:0], w_key};
                        r_count <= r_count + 3'd1;
                    end
                end else if (w_key == KEY_CLEAR) begin
                    r_buf   <= 16'd0;
                    r_count <= 3'd0;
                end else if (w_key == KEY_ENTER && r_count != 3'd0) begin
                    r_entry <= r_buf;
                    r_valid <= 1'b1;
                    r_buf   <= 16'd0;
                    r_count <= 3'd0;
                end
            end
        end
    end

    // Positions at or beyond the digit count are blanked.
    always_comb begin
        w_cur_digit = r_buf[{r_idx, 2'b00} +: 4];
        w_cur_shown = ({1'b0, r_idx} < r_count);
    end

    always_ff @(posedge fin) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
            r_seg     <= C_SEG_BLANK;
            r_dig     <= 4'd0;
        end else begin
            r_refresh <= r_refresh + 1'b1;
            if (&r_refresh) begin
                r_idx <= r_idx + 2'd1;
            end
            r_dig <= enable ? (4'b0001 << r_idx) : 4'd0;
            r_seg <= (enable && w_cur_shown) ? bcd_to_seg(w_cur_digit) : C_SEG_BLANK;
        end
    end

    assign seg         = r_seg;
    assign dig_sel     = r_dig;
    assign entry_bcd   = r_entry;
    assign entry_valid = r_valid;
    assign digit_count = r_count;

endmodule
`default_nettype wire
